scale_matrix_sequencer: RTL
===========================

# scale_matrix_sequencer

Row-serial controller that lets a single shared `scale_vector` instance scale an R×C matrix instead of instantiating R parallel vector units. It accepts one matrix through a valid/ready handshake and issues its rows one per cycle to the external vector unit. It collects the returned rows in order and presents the scaled matrix with valid/ready. It sits between the matrix-level producer/consumer and one `scale_vector`, trading throughput for area.

## Interface
- `BITS`, 16, element width.
- `R`, 2, matrix rows; ≥1.
- `C`, 2, matrix columns = vector length N of the attached `scale_vector`.
- `VEC_LATENCY`, 4, maximum `scale_vector` in_valid→out_valid latency in cycles; sizes the post-reset drain.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  matrix `a` valid.
- `in_ready`  out  1  sequencer can accept a matrix.
- `a`  in  BITS×[R][C]  input matrix; sampled only on accept.
- `out_valid`  out  1  result matrix `c` valid.
- `out_ready`  in  1  consumer accepts `c`.
- `c`  out  BITS×[R][C]  scaled matrix; stable while `out_valid`.
- `vec_in_valid`  out  1  row issue strobe to `scale_vector.in_valid`.
- `vec_a`  out  BITS×[C]  row to `scale_vector.a`.
- `vec_out_valid`  in  1  from `scale_vector.out_valid`.
- `vec_c`  in  BITS×[C]  from `scale_vector.c`.
- `err`  out  1  sticky: `vec_out_valid` seen with no row outstanding.
- `last_latency`  out  16  accept→out_valid cycle count of the last matrix (see Configuration).

## Operation
- Input buffer `a_buf[R][C]` and result buffer `c_buf[R][C]`; `c` driven from `c_buf`.
- Counters: `iss_row` and `rx_row`, width max(1,$clog2(R)); `drain_cnt` counts to `VEC_LATENCY`.
- States:
  - DRAIN: entered on reset; `in_ready`=0; `vec_out_valid` ignored; after `VEC_LATENCY` cycles → IDLE.
  - IDLE: `in_ready`=1; on `in_valid`: capture `a`, clear counters → ISSUE.
  - ISSUE: `vec_in_valid`=1, `vec_a`=`a_buf[iss_row]`, `iss_row`++; after row R−1 issued → WAIT.
  - WAIT: no issue.
  - DONE: `out_valid`=1; on `out_ready` → IDLE.
- Collection runs in ISSUE and WAIT: each `vec_out_valid` writes `vec_c` to `c_buf[rx_row]`, `rx_row`++. Write of row R−1 → DONE, even if it lands in ISSUE (only possible with latency 0; the issue count is still completed first).
- Rows return in issue order; no reordering.
- `vec_out_valid` in IDLE or DONE, or with rx count = issued count: set `err`. The data is dropped and `c_buf` is unchanged. `err` is cleared only by `rst`.
- `vec_a` is driven as 0 when `vec_in_valid`=0.
- No arithmetic on data; values pass through unchanged.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `vec_in_valid`=0, `vec_a`=0, `c`=0, `err`=0, `last_latency`=0; state DRAIN.
- The first accept is possible `VEC_LATENCY`+1 cycles after `rst` deasserts.
- Accept at cycle t. `vec_in_valid` is high t+1 … t+R.
- Vector latency L: the last row returns at t+R+L, and `out_valid` rises at t+R+L+1.
- `in_ready` is low from t+1 until the cycle after the output handshake. No overlap between matrices.
- `out_valid`&&`out_ready` in cycle k: `out_valid`=0 and `in_ready`=1 at k+1.
- `rst` mid-ISSUE, WAIT or DONE: next cycle is DRAIN and all outputs take reset values. In-flight vector results are discarded during drain and do not set `err`.
- R=1: single issue cycle; counters never wrap.

## Configuration
- `SCALE_MATRIX_SEQ_PERF_EN` defined:
  - A 16-bit saturating cycle counter clears on accept and increments every cycle until `out_valid` rises.
  - Its value loads into `last_latency` when `out_valid` rises.
- Not defined: `last_latency` is tied to 0 and no counter logic is built.

## Test plan
- R=2, C=2, stub vector with L=3 and identity pass-through, `a`={{1,2},{3,4}} accepted at t:
  - `vec_in_valid` high at t+1 and t+2, with `vec_a`={1,2} then {3,4}.
  - `out_valid` at t+6, `c`={{1,2},{3,4}}.
  - With PERF_EN, `last_latency`=6.
- Same case with `out_ready` held low 5 cycles: `c` stable, `in_ready`=0 throughout, and a new `in_valid` is not accepted until the cycle after the handshake.
- Back-to-back matrices with `in_valid` always high and `out_ready` always high: the second accept is 1 cycle after the first output handshake, and the second result is correct.
- `rst` pulsed at t+3 with a stub still returning rows at t+4 and t+5:
  - `err` stays 0 and `out_valid` never asserts.
  - `in_ready` rises `VEC_LATENCY`+1 cycles after reset.
- Spurious `vec_out_valid` in IDLE: `err`=1 next cycle and stays 1; `c` unchanged.
- R=1, C=4, L=0 stub: a single issue, the return in the same cycle, and `out_valid` at t+2.

Source files
------------

// File: rtl/scale_matrix_sequencer.sv
// ---------------------------------------------------------------------------
// scale_matrix_sequencer
//
// Purpose:
//   Row-serial controller that time-shares one external scale_vector unit
//   across an R x C matrix. The controller accepts one matrix, then issues one
//   row per cycle to the vector unit. It collects the returned rows in issue
//   order and presents the assembled result matrix. Only one matrix is in
//   flight at a time.
//
// Parameters:
//   BITS        element width
//   R           matrix rows (>= 1)
//   C           matrix columns (vector length of the attached scale_vector)
//   VEC_LATENCY maximum scale_vector in_valid -> out_valid latency; sets the
//               length of the post-reset drain window
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  matrix input handshake; a is sampled on accept
//   a                  input matrix, a[row][col]
//   out_valid/out_ready result handshake; c holds steady while out_valid
//   c                  result matrix, c[row][col]
//   vec_in_valid/vec_a row issue to scale_vector (vec_a is 0 when idle)
//   vec_out_valid/vec_c row return from scale_vector
//   err                sticky flag: a row came back with none outstanding
//   last_latency       accept -> out_valid cycle count of the last matrix
//
// Build option:
//   `define SCALE_MATRIX_SEQ_PERF_EN to build the latency counter; without it,
//   last_latency is tied to 0.
// ---------------------------------------------------------------------------
module scale_matrix_sequencer #(
   parameter int BITS        = 16,
   parameter int R           = 2,
   parameter int C           = 2,
   parameter int VEC_LATENCY = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [R-1:0][C-1:0][BITS-1:0] a,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [R-1:0][C-1:0][BITS-1:0] c,
   output logic                          vec_in_valid,
   output logic [C-1:0][BITS-1:0]        vec_a,
   input  logic                          vec_out_valid,
   input  logic [C-1:0][BITS-1:0]        vec_c,
   output logic                          err,
   output logic [15:0]                   last_latency
);

   localparam int RW = (R > 1) ? $clog2(R) : 1;
   localparam int DW = (VEC_LATENCY > 1) ? $clog2(VEC_LATENCY) : 1;
   localparam logic [RW-1:0] LAST_ROW   = RW'(R - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'((VEC_LATENCY > 0) ? VEC_LATENCY - 1 : 0);

   typedef enum logic [2:0] {
      DRAIN = 3'd0,
      IDLE  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                          state_q;
   logic [DW-1:0]                   drain_cnt_q;
   logic [RW-1:0]                   iss_row_q;
   logic [RW-1:0]                   rx_row_q;
   logic                            err_q;
   logic [R-1:0][C-1:0][BITS-1:0]   a_buf_q;
   logic [R-1:0][C-1:0][BITS-1:0]   c_buf_q;

   logic accept;
   logic rx_ok;
   logic rx_spurious;
   logic rx_last;

   // Return classification. In ISSUE the row being issued this cycle already
   // counts as outstanding, so a zero-latency unit may return it in the same
   // cycle (rx_row <= iss_row). In WAIT every row has been issued and the
   // result set is incomplete, so any return is legitimate. DRAIN discards
   // returns silently; everywhere else a return is an error.
   always_comb begin
      accept = (state_q == IDLE) && in_valid;
      rx_ok  = 1'b0;
      if (vec_out_valid) begin
         if (state_q == WAIT) begin
            rx_ok = 1'b1;
         end else if (state_q == ISSUE) begin
            rx_ok = (rx_row_q <= iss_row_q);
         end
      end
      rx_spurious = vec_out_valid && (state_q != DRAIN) && !rx_ok;
      rx_last     = rx_ok && (rx_row_q == LAST_ROW);
   end

   // Control FSM, counters, error flag and result buffer. The result buffer
   // is reset because c must read 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= DRAIN;
         drain_cnt_q <= '0;
         iss_row_q   <= '0;
         rx_row_q    <= '0;
         err_q       <= 1'b0;
         c_buf_q     <= '0;
      end else begin
         if (rx_spurious) begin
            err_q <= 1'b1;
         end
         if (rx_ok) begin
            c_buf_q[rx_row_q] <= vec_c;
            if (!rx_last) begin
               rx_row_q <= rx_row_q + RW'(1);
            end
         end
         case (state_q)
            DRAIN: begin
               if (drain_cnt_q == DRAIN_LAST) begin
                  state_q <= IDLE;
               end else begin
                  drain_cnt_q <= drain_cnt_q + DW'(1);
               end
            end
            IDLE: begin
               if (accept) begin
                  iss_row_q <= '0;
                  rx_row_q  <= '0;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               // rx_last here implies iss_row is the last row, so issuing is
               // already complete when we jump straight to DONE.
               if (rx_last) begin
                  state_q <= DONE;
               end else if (iss_row_q == LAST_ROW) begin
                  state_q <= WAIT;
               end else begin
                  iss_row_q <= iss_row_q + RW'(1);
               end
            end
            WAIT: begin
               if (rx_last) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= DRAIN;
         endcase
      end
   end

   // Input matrix buffer: pure data, only its load enable matters.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_buf_q <= a;
      end
   end

   assign in_ready     = (state_q == IDLE);
   assign out_valid    = (state_q == DONE);
   assign vec_in_valid = (state_q == ISSUE);
   assign vec_a        = vec_in_valid ? a_buf_q[iss_row_q] : '0;
   assign c            = c_buf_q;
   assign err          = err_q;

`ifdef SCALE_MATRIX_SEQ_PERF_EN
   logic [15:0] perf_cnt_q;
   logic [15:0] last_lat_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // The counter starts at 1 in the first cycle after accept, so the value
   // captured on the DONE transition equals accept -> out_valid distance.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cnt_q <= '0;
         last_lat_q <= '0;
      end else begin
         if (accept) begin
            perf_cnt_q <= 16'd1;
         end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
            perf_cnt_q <= sat_inc(perf_cnt_q);
         end
         if (rx_last) begin
            last_lat_q <= sat_inc(perf_cnt_q);
         end
      end
   end

   assign last_latency = last_lat_q;
`else
   assign last_latency = 16'd0;
`endif

endmodule
